pq_auto_sequencer: RTL and testbench

- Autonomous controller that exercises the 16-bit priority queue in the high-level demo.
- It generates pseudo-random 16-bit keys with an LFSR and enqueues them until the queue is full.
- It then dequeues until empty, presenting each dequeued key on data1/data2 and the RGB outputs for a fixed dwell.
- It flags any ordering violation (min-queue: dequeued keys must be non-decreasing) and exports one-hot state indicators for debug/display.

---
 rtl/pq_auto_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_pq_auto_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_auto_sequencer.sv
// Autonomous driver for the demo priority queue: fills it with LFSR keys, drains it,
// displays each dequeued key for a fixed dwell and flags any min-order violation.
module pq_auto_sequencer #(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned DISPLAY_CYCLES = 4,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        pq_req,
    output logic        pq_op,
    output logic [15:0] pq_key,
    input  logic        pq_ack,
    input  logic [15:0] pq_key_out,
    input  logic        pq_full,
    input  logic        pq_empty,
    output logic [7:0]  data1,
    output logic [7:0]  data2,
    output logic [2:0]  red,
    output logic [2:0]  green,
    output logic [2:0]  blue,
    output logic        sigIDLE,
    output logic        sigSTART,
    output logic        sigADD,
    output logic        sigREMOVE,
    output logic        sigDISPLAY,
    output logic        sigFULL,
    output logic        sigEMPTY,
    output logic [4:0]  count,
    output logic        err
);

    localparam logic [4:0]  DepthCnt  = 5'(DEPTH);
    localparam logic [15:0] DwellLast = 16'(DISPLAY_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StStart, StAdd, StFull, StRemove, StDisplay, StEmpty
    } state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        op_q, op_d;
    logic [15:0] key_q, key_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] prev_q, prev_d;
    logic [15:0] last_q, last_d;
    logic [15:0] dwell_q, dwell_d;
    logic [4:0]  count_q, count_d;
    logic        err_q, err_d;
    logic [2:0]  red_q, red_d;
    logic [2:0]  green_q, green_d;
    logic [2:0]  blue_q, blue_d;

    logic        ack_seen;
    logic [4:0]  count_inc;
    logic [4:0]  count_dec;
    logic [15:0] lfsr_next;

    // An ack only counts while a request is outstanding.
    assign ack_seen  = req_q & pq_ack;
    assign count_inc = count_q + 5'd1;
    assign count_dec = (count_q == 5'd0) ? 5'd0 : count_q - 5'd1;
    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        op_d    = op_q;
        key_d   = key_q;
        lfsr_d  = lfsr_q;
        prev_d  = prev_q;
        last_d  = last_q;
        dwell_d = dwell_q;
        count_d = count_q;
        err_d   = err_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;

        case (state_q)
            StIdle: begin
                if (start) state_d = StStart;
            end
            StStart: begin
                count_d = 5'd0;
                err_d   = 1'b0;
                prev_d  = 16'd0;
                red_d   = 3'd0;
                green_d = 3'd0;
                blue_d  = 3'd0;
                state_d = StAdd;
            end
            StAdd: begin
                if (ack_seen) begin
                    req_d   = 1'b0;
                    count_d = count_inc;
                    lfsr_d  = lfsr_next;
                    if (pq_full || count_inc == DepthCnt) state_d = StFull;
                end else if (!req_q) begin
                    req_d = 1'b1;
                    op_d  = 1'b0;
                    key_d = lfsr_q;
                end
            end
            StFull: begin
                state_d = StRemove;
            end
            StRemove: begin
                if (ack_seen) begin
                    req_d   = 1'b0;
                    last_d  = pq_key_out;
                    err_d   = err_q | (pq_key_out < prev_q);
                    prev_d  = pq_key_out;
                    count_d = count_dec;
                    red_d   = err_d ? 3'b111 : 3'b000;
                    green_d = err_d ? 3'b000 : 3'b111;
                    blue_d  = count_dec[2:0];
                    dwell_d = 16'd0;
                    state_d = StDisplay;
                end else if (!req_q) begin
                    // Queue-side empty wins over our own count.
                    if (pq_empty || count_q == 5'd0) begin
                        state_d = StEmpty;
                    end else begin
                        req_d = 1'b1;
                        op_d  = 1'b1;
                    end
                end
            end
            StDisplay: begin
                if (dwell_q == DwellLast) begin
                    state_d = (count_q == 5'd0) ? StEmpty : StRemove;
                end else begin
                    dwell_d = dwell_q + 16'd1;
                end
            end
            StEmpty: begin
                red_d   = 3'd0;
                green_d = 3'd0;
                blue_d  = 3'd0;
                state_d = start ? StStart : StIdle;
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            op_q    <= 1'b0;
            key_q   <= 16'd0;
            lfsr_q  <= SEED;
            prev_q  <= 16'd0;
            last_q  <= 16'd0;
            dwell_q <= 16'd0;
            count_q <= 5'd0;
            err_q   <= 1'b0;
            red_q   <= 3'd0;
            green_q <= 3'd0;
            blue_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            op_q    <= op_d;
            key_q   <= key_d;
            lfsr_q  <= lfsr_d;
            prev_q  <= prev_d;
            last_q  <= last_d;
            dwell_q <= dwell_d;
            count_q <= count_d;
            err_q   <= err_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign pq_req     = req_q;
    assign pq_op      = op_q;
    assign pq_key     = key_q;
    assign data1      = last_q[15:8];
    assign data2      = last_q[7:0];
    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;
    assign count      = count_q;
    assign err        = err_q;
    assign sigIDLE    = (state_q == StIdle);
    assign sigSTART   = (state_q == StStart);
    assign sigADD     = (state_q == StAdd);
    assign sigREMOVE  = (state_q == StRemove);
    assign sigDISPLAY = (state_q == StDisplay);
    assign sigFULL    = (state_q == StFull);
    assign sigEMPTY   = (state_q == StEmpty);

endmodule

// File: tb/tb_pq_auto_sequencer.sv
// Directed bench: a behavioural min-queue answers the sequencer with a two-cycle ack latency.
module tb_pq_auto_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        pq_req;
    logic        pq_op;
    logic [15:0] pq_key;
    logic        pq_ack;
    logic [15:0] pq_key_out;
    logic        pq_full;
    logic        pq_empty;
    logic [7:0]  data1;
    logic [7:0]  data2;
    logic [2:0]  red;
    logic [2:0]  green;
    logic [2:0]  blue;
    logic        sigIDLE;
    logic        sigSTART;
    logic        sigADD;
    logic        sigREMOVE;
    logic        sigDISPLAY;
    logic        sigFULL;
    logic        sigEMPTY;
    logic [4:0]  count;
    logic        err;

    pq_auto_sequencer #(
        .DEPTH          (16),
        .DISPLAY_CYCLES (4),
        .SEED           (16'hACE1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pq_req     (pq_req),
        .pq_op      (pq_op),
        .pq_key     (pq_key),
        .pq_ack     (pq_ack),
        .pq_key_out (pq_key_out),
        .pq_full    (pq_full),
        .pq_empty   (pq_empty),
        .data1      (data1),
        .data2      (data2),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .sigIDLE    (sigIDLE),
        .sigSTART   (sigSTART),
        .sigADD     (sigADD),
        .sigREMOVE  (sigREMOVE),
        .sigDISPLAY (sigDISPLAY),
        .sigFULL    (sigFULL),
        .sigEMPTY   (sigEMPTY),
        .count      (count),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- queue model ----------------
    int          full_lim   = 16;
    logic        force_mode = 1'b0;
    int          force_n    = 0;
    int          mcount;
    int          wcnt;
    logic [15:0] mem [16];
    int          enq_total = 0;
    int          deq_total = 0;
    logic [15:0] enq_keys [128];
    int          mi;
    logic [15:0] ret;

    assign pq_full  = (mcount >= full_lim);
    assign pq_empty = (mcount == 0);

    function automatic int min_idx();
        int m = 0;
        for (int i = 1; i < mcount; i++) if (mem[i] < mem[m]) m = i;
        return m;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pq_ack     <= 1'b0;
            pq_key_out <= 16'd0;
            wcnt       <= 0;
            mcount     <= 0;
        end else begin
            pq_ack <= 1'b0;
            if (pq_req && !pq_ack) begin
                if (wcnt == 1) begin
                    wcnt   <= 0;
                    pq_ack <= 1'b1;
                    if (!pq_op) begin
                        if (mcount < 16) begin
                            mem[mcount] <= pq_key;
                            mcount      <= mcount + 1;
                        end
                        if (enq_total < 128) enq_keys[enq_total] <= pq_key;
                        enq_total <= enq_total + 1;
                    end else if (mcount > 0) begin
                        mi  = min_idx();
                        ret = force_mode ? ((force_n == 0) ? 16'h0100 : 16'h00FF) : mem[mi];
                        if (force_mode) force_n <= force_n + 1;
                        mem[mi]    <= mem[mcount-1];
                        mcount     <= mcount - 1;
                        pq_key_out <= ret;
                        deq_total  <= deq_total + 1;
                    end
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    // ---------------- expected keys ----------------
    logic [15:0] bench_keys [64];
    logic [15:0] exp_sorted [16];

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic load_sorted(input int first, input int n);
        logic [15:0] t;
        for (int i = 0; i < n; i++) exp_sorted[i] = bench_keys[first + i];
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n - 1 - i; j++)
                if (exp_sorted[j] > exp_sorted[j+1]) begin
                    t               = exp_sorted[j];
                    exp_sorted[j]   = exp_sorted[j+1];
                    exp_sorted[j+1] = t;
                end
    endtask

    task automatic observe_display(input string tag, input logic [15:0] key,
                                   input logic [2:0] b, input logic e);
        int n = 0;
        while (!sigDISPLAY && n < 40) begin @(negedge clk); n++; end
        n = 0;
        while (sigDISPLAY && n < 20) begin
            check({tag, "_data"}, {data1, data2}, key);
            check({tag, "_rgb_err"}, {red, green, blue, err},
                  {(e ? 3'b111 : 3'b000), (e ? 3'b000 : 3'b111), b, e});
            @(negedge clk);
            n++;
        end
        check({tag, "_dwell"}, n, 4);
    endtask

    task automatic wait_full(input string tag);
        int n = 0;
        while (!sigFULL && n < 300) begin @(negedge clk); n++; end
        check({tag, "_seen"}, sigFULL, 1'b1);
    endtask

    int n;
    int snap_enq;
    int snap_deq;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bench_keys[0] = 16'hACE1;
        for (int i = 1; i < 64; i++) bench_keys[i] = lfsr_step(bench_keys[i-1]);

        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Idle with start low: everything at reset values.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outputs",
                  {sigIDLE, sigSTART, sigADD, sigREMOVE, sigDISPLAY, sigFULL, sigEMPTY,
                   pq_req, pq_op, pq_key, data1, data2, red, green, blue, count, err},
                  {7'b1000000, 49'd0});
        end

        // Pass 1: fill 16, drain sorted.
        start = 1'b1;
        n = 0;
        while (!pq_req && n < 10) begin @(negedge clk); n++; end
        check("first_req", pq_req, 1'b1);
        check("first_req_op_key", {pq_op, pq_key}, {1'b0, 16'hACE1});
        wait_full("p1_full");
        check("p1_full_count", count, 5'd16);
        check("p1_enq_total", enq_total, 16);
        check("p1_key0", enq_keys[0], 16'hACE1);
        check("p1_key1", enq_keys[1], 16'h59C3);
        for (int i = 2; i < 16; i++) check("p1_keyseq", enq_keys[i], bench_keys[i]);
        @(negedge clk);
        check("p1_full_pulse", {sigFULL, sigREMOVE}, 2'b01);
        load_sorted(0, 16);
        for (int i = 0; i < 16; i++) observe_display("p1", exp_sorted[i], 3'(15 - i), 1'b0);
        check("p1_empty", {sigEMPTY, count, err, pq_req}, {1'b1, 5'd0, 1'b0, 1'b0});
        force_mode = 1'b1;
        @(negedge clk);
        check("p1_restart", sigSTART, 1'b1);

        // Pass 2: queue returns 0100 then 00FF -> ordering error.
        wait_full("p2_full");
        check("p2_full_count", count, 5'd16);
        observe_display("p2_d0", 16'h0100, 3'd7, 1'b0);
        for (int i = 1; i < 16; i++) observe_display("p2", 16'h00FF, 3'(15 - i), 1'b1);
        check("p2_empty_err", {sigEMPTY, err}, 2'b11);
        force_mode = 1'b0;
        full_lim   = 5;
        @(negedge clk);
        check("p2_start_err_held", {sigSTART, err}, 2'b11);
        @(negedge clk);
        check("p2_err_cleared", {sigADD, err, count}, {1'b1, 1'b0, 5'd0});

        // Pass 3: queue reports full after 5 enqueues.
        snap_enq = enq_total;
        wait_full("p3_full");
        check("p3_full_count", count, 5'd5);
        check("p3_enq_count", enq_total - snap_enq, 5);
        snap_deq = deq_total;
        load_sorted(32, 5);
        for (int i = 0; i < 5; i++) observe_display("p3", exp_sorted[i], 3'(4 - i), 1'b0);
        check("p3_empty", {sigEMPTY, count}, {1'b1, 5'd0});
        check("p3_deq_count", deq_total - snap_deq, 5);

        // Pass 4: reset while a dequeue is outstanding.
        n = 0;
        while (!(sigREMOVE && pq_req) && n < 300) begin @(negedge clk); n++; end
        check("p4_remove_req", {sigREMOVE, pq_req}, 2'b11);
        rst = 1'b0;
        #1;
        check("p4_async_reset", {sigIDLE, sigREMOVE, pq_req, count}, {3'b100, 5'd0});
        repeat (2) @(negedge clk);
        snap_enq = enq_total;
        rst = 1'b1;
        n = 0;
        while (enq_total == snap_enq && n < 50) begin @(negedge clk); n++; end
        check("p4_enq_after_reset", enq_total - snap_enq, 1);
        check("p4_first_key", enq_keys[snap_enq], 16'hACE1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
